pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter SIZE_ADDR_BR, default 5: register-address width.
REQ-002 Parameter SIZE_OP, default 6: opcode width.
REQ-003 Parameter HALT_OP, default 6'b111111: opcode that requests halt.
REQ-004 Parameter DRAIN_CYCLES, default 3: bubble cycles inserted before HALTED.
REQ-005 Parameter CNT_W, default 16: event-counter width.
REQ-006 Ports: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  leave IDLE/HALTED and run.
REQ-010 id_rs  in  SIZE_ADDR_BR  source reg 1 of the IF/ID instruction.
REQ-011 id_rt  in  SIZE_ADDR_BR  source reg 2 of the IF/ID instruction.
REQ-012 id_opcode  in  SIZE_OP  opcode of the IF/ID instruction.
REQ-013 ex_memread  in  1  MemRead of the ID/EX instruction.
REQ-014 ex_rt  in  SIZE_ADDR_BR  load destination in ID/EX.
REQ-015 mem_branch_taken  in  1  branch resolved taken in EX/MEM.
REQ-016 pc_we  out  1  PC load enable.
REQ-017 ifid_we  out  1  IF/ID load enable.
REQ-018 ifid_flush  out  1  IF/ID clears to NOP.
REQ-019 idex_bubble  out  1  ID/EX loads zero control (WB/M/EX).
REQ-020 exmem_flush  out  1  EX/MEM loads zero control.
REQ-021 state  out  3  IDLE=0, RUN=1, DRAIN=2, HALTED=3.
REQ-022 halted  out  1  high in HALTED.
REQ-023 stall_cnt  out  CNT_W  load-use stall count.
REQ-024 flush_cnt  out  CNT_W  taken-branch flush count.

Function
REQ-025 IDLE: all enables/flush/bubble 0; start=1 -> RUN next edge.
REQ-026 RUN default: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, exmem_flush=0.
REQ-027 load_use = ex_memread & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt), combinational.
REQ-028 RUN, mem_branch_taken=1 (highest priority), same cycle: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; flush_cnt+1; stay RUN.
REQ-029 RUN, load_use=1 and no branch, same cycle: pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt+1; stay RUN.
REQ-030 RUN, id_opcode==HALT_OP, no branch, no load_use: that cycle ifid_flush=1, pc_we=0; -> DRAIN with drain counter=DRAIN_CYCLES-1.
REQ-031 Taken branch in same cycle as HALT_OP: branch wins, halt discarded (halt instruction is flushed).
REQ-032 DRAIN: pc_we=0, ifid_we=0, idex_bubble=1, exmem_flush=0; counter decrements; at 0 -> HALTED; branch/load_use ignored.
REQ-033 HALTED: halted=1, all enables 0; start=1 -> RUN next edge; counters retained.
REQ-034 start ignored in RUN and DRAIN.
REQ-035 Counters saturate at 2^CNT_W-1; no wrap.
REQ-036 Mealy outputs (REQ-028..030) valid in the same cycle as the inputs; state and counters update on clk rising edge.

Reset
REQ-037 reset=0 asynchronously forces state=IDLE, all enables/flush/bubble/halted=0, stall_cnt=0, flush_cnt=0, drain counter=0, independent of clk.
REQ-038 Reset asserted mid-DRAIN or mid-stall aborts it; after release the block sits in IDLE until start.
REQ-039 First edge after reset release with start=1 enters RUN.

Verification
REQ-040 reset low, start=1 -> IDLE holds, outputs 0; release, start pulse -> state=1, pc_we=ifid_we=1 next cycle.
REQ-041 RUN, ex_memread=1, ex_rt=5, id_rs=5 -> pc_we=0, ifid_we=0, idex_bubble=1 same cycle, stall_cnt=1; with ex_rt=0 -> no stall.
REQ-042 RUN, mem_branch_taken=1 plus load_use=1 -> ifid_flush=idex_bubble=exmem_flush=1, pc_we=1, flush_cnt=1, stall_cnt unchanged.
REQ-043 RUN, id_opcode=6'h3F -> ifid_flush=1; 3 DRAIN cycles with idex_bubble=1; then state=3, halted=1; start -> RUN.
REQ-044 reset pulsed low during DRAIN cycle 2 -> immediate IDLE, counters 0; CNT_W=2 with 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flow controller: load-use stalls, taken-branch flushes and a
// halt sequence that drains the pipe with bubbles before parking in HALTED.
module pipeline_ctrl #(
  parameter int                  SIZE_ADDR_BR = 5,
  parameter int                  SIZE_OP      = 6,
  parameter logic [SIZE_OP-1:0]  HALT_OP      = {SIZE_OP{1'b1}},
  parameter int                  DRAIN_CYCLES = 3,
  parameter int                  CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SIZE_ADDR_BR-1:0] id_rs,
  input  logic [SIZE_ADDR_BR-1:0] id_rt,
  input  logic [SIZE_OP-1:0]      id_opcode,
  input  logic                    ex_memread,
  input  logic [SIZE_ADDR_BR-1:0] ex_rt,
  input  logic                    mem_branch_taken,
  output logic                    pc_we,
  output logic                    ifid_we,
  output logic                    ifid_flush,
  output logic                    idex_bubble,
  output logic                    exmem_flush,
  output logic [2:0]              state,
  output logic                    halted,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  // The halt cycle itself loads DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES cycles.
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3
  } state_t;

  state_t           state_reg;
  logic [DW-1:0]    drain_reg;
  logic [CNT_W-1:0] stall_reg;
  logic [CNT_W-1:0] flush_reg;
  logic             load_use;
  logic             halt_req;

  assign load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign halt_req = (id_opcode == HALT_OP);

  // Control outputs must react in the same cycle as the hazard inputs, so they
  // are decoded combinationally from the registered state.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (mem_branch_taken) begin
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          idex_bubble = 1'b1;
        end else if (halt_req) begin
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      S_DRAIN: idex_bubble = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      drain_reg <= '0;
      stall_reg <= '0;
      flush_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_HALTED: begin
          if (start) state_reg <= S_RUN;
        end
        S_RUN: begin
          if (mem_branch_taken) begin
            if (flush_reg != {CNT_W{1'b1}}) flush_reg <= flush_reg + CNT_W'(1);
          end else if (load_use) begin
            if (stall_reg != {CNT_W{1'b1}}) stall_reg <= stall_reg + CNT_W'(1);
          end else if (halt_req) begin
            state_reg <= S_DRAIN;
            drain_reg <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (drain_reg == '0) state_reg <= S_HALTED;
          else                 drain_reg <= drain_reg - DW'(1);
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign state     = state_reg;
  assign halted    = (state_reg == S_HALTED);
  assign stall_cnt = stall_reg;
  assign flush_cnt = flush_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, all checked
// against a rule-level model; a second instance with CNT_W=2 exercises saturation.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic [5:0] id_opcode = '0;
  logic       ex_memread = 1'b0, mem_branch_taken = 1'b0;

  logic        a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_exmem_flush, a_halted;
  logic [2:0]  a_state;
  logic [15:0] a_stall, a_flush;
  logic        b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_exmem_flush, b_halted;
  logic [2:0]  b_state;
  logic [1:0]  b_stall, b_flush;

  pipeline_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start), .id_rs(id_rs), .id_rt(id_rt),
    .id_opcode(id_opcode), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .pc_we(a_pc_we), .ifid_we(a_ifid_we),
    .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .exmem_flush(a_exmem_flush),
    .state(a_state), .halted(a_halted), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipeline_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .id_rs(id_rs), .id_rt(id_rt),
    .id_opcode(id_opcode), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .pc_we(b_pc_we), .ifid_we(b_ifid_we),
    .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .exmem_flush(b_exmem_flush),
    .state(b_state), .halted(b_halted), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 idle, 1 run, 2 draining, 3 halted; left = drain cycles remaining.
  int     m_state = 0;
  int     m_left  = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lu_now();
    return ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  // Expected {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, halted} and a care mask.
  task automatic model_outputs(output logic [5:0] e, output logic [5:0] m);
    m = 6'b111111;
    e = 6'b000000;
    case (m_state)
      1: begin
        if (mem_branch_taken)        e = 6'b111110;
        else if (lu_now())           e = 6'b000100;
        else if (id_opcode == 6'h3F) begin e = 6'b001000; m = 6'b101111; end
        else                         e = 6'b110000;
      end
      2: begin e = 6'b000100; m = 6'b110111; end
      3: e = 6'b000001;
      default: e = 6'b000000;
    endcase
  endtask

  task automatic check_comb();
    logic [5:0] e, m, oa, ob;
    model_outputs(e, m);
    oa = {a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_exmem_flush, a_halted};
    ob = {b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_exmem_flush, b_halted};
    chk("ctl_a", 32'(oa & m), 32'(e & m));
    chk("ctl_b", 32'(ob & m), 32'(e & m));
  endtask

  task automatic check_regs();
    longint sb, fb;
    sb = (m_stall > 3) ? 3 : m_stall;
    fb = (m_flush > 3) ? 3 : m_flush;
    chk("state_a", 32'(a_state), 32'(m_state));
    chk("state_b", 32'(b_state), 32'(m_state));
    chk("stall_a", 32'(a_stall), 32'(m_stall));
    chk("flush_a", 32'(a_flush), 32'(m_flush));
    chk("stall_b", 32'(b_stall), 32'(sb));
    chk("flush_b", 32'(b_flush), 32'(fb));
  endtask

  task automatic model_advance();
    if (!reset) begin
      m_state = 0; m_left = 0; m_stall = 0; m_flush = 0;
      return;
    end
    case (m_state)
      0, 3: if (start) m_state = 1;
      1: begin
        if (mem_branch_taken) begin
          if (m_flush < 65535) m_flush++;
        end else if (lu_now()) begin
          if (m_stall < 65535) m_stall++;
        end else if (id_opcode == 6'h3F) begin
          m_state = 2;
          m_left  = 3;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) m_state = 3;
      end
      default: m_state = 0;
    endcase
  endtask

  // Inputs are driven at posedge+1; outputs checked mid-cycle and just after the edge.
  task automatic cycle();
    #2;
    check_comb();
    @(posedge clk);
    model_advance();
    #1;
    check_regs();
  endtask

  task automatic reset_mid_cycle();
    #2;
    reset = 1'b0;
    #1;
    m_state = 0; m_left = 0; m_stall = 0; m_flush = 0;
    check_comb();
    check_regs();
    @(posedge clk);
    #1;
    check_comb();
    check_regs();
    reset = 1'b1;
  endtask

  task automatic set_in(input bit br, input bit mr, input int ert, input int rs,
                        input int rt, input int op);
    mem_branch_taken = br;
    ex_memread = mr;
    ex_rt = 5'(ert);
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_opcode = 6'(op);
  endtask

  initial begin
    // Reset held with start=1: block must stay idle.
    start = 1'b1;
    #1;
    repeat (2) begin
      #2;
      check_comb();
      @(posedge clk);
      #1;
      check_regs();
    end
    reset = 1'b1;
    start = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("run_after_start", 32'(a_state), 32'd1);
    cycle();

    // Load-use stall, then the same registers with ex_rt=0.
    set_in(0, 1, 5, 5, 0, 0);
    cycle();
    chk("stall_one", 32'(a_stall), 32'd1);
    set_in(0, 1, 0, 0, 0, 0);
    cycle();
    chk("no_stall_rt0", 32'(a_stall), 32'd1);

    // Branch beats load-use, then branch beats halt.
    set_in(1, 1, 5, 5, 0, 0);
    cycle();
    chk("flush_one", 32'(a_flush), 32'd1);
    set_in(1, 0, 0, 0, 0, 6'h3F);
    cycle();
    chk("halt_dropped", 32'(a_state), 32'd1);

    // Four more stalls (via id_rt) so the 2-bit instance saturates.
    repeat (4) begin
      set_in(0, 1, 7, 1, 7, 0);
      cycle();
    end
    chk("stall_sat", 32'(b_stall), 32'd3);

    // Halt, drain with hazards ignored, then restart from HALTED.
    set_in(0, 0, 0, 0, 0, 6'h3F);
    cycle();
    set_in(1, 1, 4, 4, 4, 0);
    start = 1'b1;
    repeat (3) cycle();
    start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    chk("halted_flag", 32'(a_halted), 32'd1);
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_run", 32'(a_state), 32'd1);

    // Reset during drain cycle 2.
    set_in(0, 0, 0, 0, 0, 6'h3F);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    reset_mid_cycle();
    chk("reset_stall_clr", 32'(a_stall), 32'd0);
    cycle();
    start = 1'b1;
    cycle();

    // Random traffic with dense register collisions.
    for (int i = 0; i < 1500; i++) begin
      mem_branch_taken = ($urandom_range(0, 5) == 0);
      ex_memread = $urandom_range(0, 1) == 1;
      ex_rt = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_opcode = ($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) reset_mid_cycle();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
